// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encoding,
// controller states and the divide-by-zero LO value.
package muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam logic [31:0] MD_DIVZERO_LO = 32'hFFFF_FFFF;

  // Two's-complement negation of a 32-bit value.
  function automatic logic [31:0] md_neg32(input logic [31:0] v);
    return 32'd0 - v;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit multiply/divide unit with HI/LO for the E stage.
// Operands are reduced to magnitudes at start, the unsigned core runs one
// bit per cycle for 32 cycles, and signs are re-applied in the FIX cycle.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cancel,
  input  logic        e_bubble,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] wdata,
  input  logic        d_need_hilo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        stall_hilo
);

  md_state_e   state_r, state_nxt_s;
  logic        accept_s;
  logic [4:0]  count_r;
  logic [63:0] acc_r;        // multiply: {partial product, multiplier}; divide: {rem, quot}
  logic [31:0] opd_r;        // multiplicand or divisor magnitude
  logic [31:0] a_orig_r;     // raw dividend, returned in HI on divide by zero
  logic        is_div_r;
  logic        neg_res_r;
  logic        neg_rem_r;
  logic        divzero_r;
  logic [31:0] hi_r, lo_r;
  logic        busy_r;

  logic        signed_op_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic [32:0] mul_sum_s;
  logic [63:0] mul_next_s;
  logic [32:0] div_rem_s;
  logic        div_ge_s;
  logic [31:0] div_diff_s;
  logic [63:0] div_next_s;
  logic [63:0] prod_s;
  logic [31:0] quot_s, rem_s;

  // Operand magnitudes and one iteration step of the shift-add / restoring core.
  always_comb begin
    signed_op_s = (op == MD_MULT) || (op == MD_DIV);
    mag_a_s     = (signed_op_s && a[31]) ? md_neg32(a) : a;
    mag_b_s     = (signed_op_s && b[31]) ? md_neg32(b) : b;
    mul_sum_s   = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opd_r} : 33'd0);
    mul_next_s  = {mul_sum_s, acc_r[31:1]};
    div_rem_s   = acc_r[63:31];
    div_ge_s    = (div_rem_s >= {1'b0, opd_r});
    div_diff_s  = div_rem_s[31:0] - opd_r;
    div_next_s  = div_ge_s ? {div_diff_s, acc_r[30:0], 1'b1} : {acc_r[62:0], 1'b0};
    prod_s      = neg_res_r ? (64'd0 - acc_r) : acc_r;
    quot_s      = neg_res_r ? md_neg32(acc_r[31:0]) : acc_r[31:0];
    rem_s       = neg_rem_r ? md_neg32(acc_r[63:32]) : acc_r[63:32];
  end

  // Next-state decode; cancel wins over both start and completion.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      MD_IDLE: begin
        if (start && !e_bubble && !cancel) begin
          accept_s    = 1'b1;
          state_nxt_s = MD_RUN;
        end else begin
          state_nxt_s = MD_IDLE;
        end
      end
      MD_RUN: begin
        if (cancel) begin
          state_nxt_s = MD_IDLE;
        end else if (count_r == 5'd31) begin
          state_nxt_s = MD_FIX;
        end else begin
          state_nxt_s = MD_RUN;
        end
      end
      MD_FIX:  state_nxt_s = MD_IDLE;
      default: state_nxt_s = MD_IDLE;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_r <= MD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Operand capture, iteration counter, datapath accumulator and busy flag.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      count_r   <= 5'd0;
      acc_r     <= 64'd0;
      opd_r     <= 32'd0;
      a_orig_r  <= 32'd0;
      is_div_r  <= 1'b0;
      neg_res_r <= 1'b0;
      neg_rem_r <= 1'b0;
      divzero_r <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      busy_r <= (state_nxt_s != MD_IDLE);
      if (accept_s) begin
        count_r   <= 5'd0;
        acc_r     <= {32'd0, mag_a_s};
        opd_r     <= mag_b_s;
        a_orig_r  <= a;
        is_div_r  <= op[1];
        neg_res_r <= signed_op_s && (a[31] ^ b[31]);
        neg_rem_r <= signed_op_s && op[1] && a[31];
        divzero_r <= (b == 32'd0);
      end else if (state_r == MD_RUN) begin
        count_r <= count_r + 5'd1;
        acc_r   <= is_div_r ? div_next_s : mul_next_s;
      end
    end
  end

  // Architectural HI/LO: result commit in FIX, MTHI/MTLO only while idle.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      hi_r <= 32'd0;
      lo_r <= 32'd0;
    end else if ((state_r == MD_FIX) && !cancel) begin
      if (!is_div_r) begin
        hi_r <= prod_s[63:32];
        lo_r <= prod_s[31:0];
      end else if (divzero_r) begin
        hi_r <= a_orig_r;
        lo_r <= MD_DIVZERO_LO;
      end else begin
        hi_r <= rem_s;
        lo_r <= quot_s;
      end
    end else if (state_r == MD_IDLE) begin
      if (wr_hi) hi_r <= wdata;
      if (wr_lo) lo_r <= wdata;
    end
  end

  assign hi         = hi_r;
  assign lo         = lo_r;
  assign busy       = busy_r;
  assign stall_hilo = busy_r & d_need_hilo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes the expected HI/LO of
// each operation, a negedge monitor pops and compares when busy falls.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        cancel = 1'b0;
  logic        e_bubble = 1'b0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        d_need_hilo = 1'b0;
  logic [31:0] hi, lo;
  logic        busy, stall_hilo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;   // expected busy length, -1 when aborted
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mdl_hi = 32'd0;
  logic [31:0] mdl_lo = 32'd0;
  logic        prev_busy = 1'b0;
  int          bcnt = 0;

  muldiv_unit dut (
    .clk(clk), .clrn(clrn), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .e_bubble(e_bubble), .wr_hi(wr_hi), .wr_lo(wr_lo),
    .wdata(wdata), .d_need_hilo(d_need_hilo), .hi(hi), .lo(lo),
    .busy(busy), .stall_hilo(stall_hilo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic in the language's own operators.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          sx, sy, q, r;
    longint unsigned ux, uy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    case (o)
      2'd0: return sx * sy;
      2'd1: return ux * uy;
      2'd2: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // Monitor: counts busy cycles and scores each result when busy falls.
  always @(negedge clk) begin
    exp_t e;
    if (busy) begin
      bcnt++;
    end else if (prev_busy) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("res_hi", {32'd0, hi}, {32'd0, e.hi});
        check("res_lo", {32'd0, lo}, {32'd0, e.lo});
        if (e.cyc >= 0) check("busy_len", 64'(bcnt), 64'(e.cyc));
      end
      bcnt = 0;
    end
    prev_busy = busy;
  end

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy) check("idle_timeout", 64'd1, 64'd0);
  endtask

  // Drive a one-cycle start and record what HI/LO must become.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [63:0] exp, input int cyc);
    exp_t e;
    e.hi = exp[63:32];
    e.lo = exp[31:0];
    e.cyc = cyc;
    start = 1'b1; op = o; a = x; b = y;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Full operation, or one cancelled cancel_at cycles after acceptance.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] exp, input int cancel_at);
    wait_idle();
    if (cancel_at < 0) begin
      issue(o, x, y, exp, 33);
      wait_idle();
      mdl_hi = exp[63:32];
      mdl_lo = exp[31:0];
    end else begin
      issue(o, x, y, {mdl_hi, mdl_lo}, -1);
      repeat (cancel_at) @(posedge clk);
      #1;
      cancel = 1'b1;
      @(posedge clk);
      #1;
      cancel = 1'b0;
      check("cancel_busy", {63'd0, busy}, 64'd0);
      check("cancel_hilo", {hi, lo}, {mdl_hi, mdl_lo});
    end
  endtask

  initial begin
    logic [1:0]  o;
    logic [31:0] x, y;
    exp_t        e;

    // Reset state.
    d_need_hilo = 1'b1;
    #12;
    check("rst_hilo", {hi, lo}, 64'd0);
    check("rst_busy", {62'd0, busy, stall_hilo}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    d_need_hilo = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases with hand-computed results.
    run_op(2'd0, 32'hFFFF_FFFD, 32'd7, {32'hFFFF_FFFF, 32'hFFFF_FFEB}, -1);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001}, -1);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, -1);
    run_op(2'd3, 32'd7, 32'd0, {32'd7, 32'hFFFF_FFFF}, -1);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, -1);
    run_op(2'd2, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF}, -1);

    // MTHI/MTLO together while idle.
    wdata = 32'hA5A5_1234; wr_hi = 1'b1; wr_lo = 1'b1;
    @(posedge clk);
    #1;
    wr_hi = 1'b0; wr_lo = 1'b0;
    mdl_hi = 32'hA5A5_1234; mdl_lo = 32'hA5A5_1234;
    check("mt_both", {hi, lo}, {mdl_hi, mdl_lo});

    // start during a bubble is ignored.
    start = 1'b1; e_bubble = 1'b1; op = 2'd1; a = 32'd3; b = 32'd3;
    @(posedge clk);
    #1;
    start = 1'b0; e_bubble = 1'b0;
    check("bubble_start", {63'd0, busy}, 64'd0);

    // Stall held through RUN and FIX; a stray MTLO mid-RUN is ignored.
    d_need_hilo = 1'b1;
    x = 32'd1000; y = 32'd77;
    issue(2'd3, x, y, ref_result(2'd3, x, y), 33);
    for (int i = 0; i < 33; i++) begin
      check("stall_run", {63'd0, stall_hilo}, 64'd1);
      check("lo_hold", {32'd0, lo}, {32'd0, mdl_lo});
      wr_lo = (i >= 1 && i <= 30);
      wdata = 32'hDEAD_BEEF;
      @(posedge clk);
      #1;
    end
    wr_lo = 1'b0;
    check("stall_done", {62'd0, busy, stall_hilo}, 64'd0);
    d_need_hilo = 1'b0;
    mdl_hi = 32'd76; mdl_lo = 32'd12;

    // Cancel at RUN cycle 10, then a normal MULTU.
    run_op(2'd0, 32'd123, 32'd456, 64'd0, 10);
    run_op(2'd1, 32'd5, 32'd6, {32'd0, 32'd30}, -1);

    // Asynchronous reset mid-RUN.
    wait_idle();
    issue(2'd1, 32'd9, 32'd9, 64'd81, 33);
    repeat (5) @(posedge clk);
    #2;
    clrn = 1'b0;
    void'(sb_q.pop_back());
    e.hi = 32'd0; e.lo = 32'd0; e.cyc = -1;
    sb_q.push_back(e);
    d_need_hilo = 1'b1;
    #1;
    check("arst_hilo", {hi, lo}, 64'd0);
    check("arst_busy", {62'd0, busy, stall_hilo}, 64'd0);
    @(negedge clk);
    clrn = 1'b1;
    d_need_hilo = 1'b0;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    @(posedge clk);
    #1;
    run_op(2'd0, 32'hFFFF_FFFE, 32'hFFFF_FFFB, {32'd0, 32'd10}, -1);

    // Randomised operations with occasional cancels.
    for (int k = 0; k < 24; k++) begin
      o = 2'($urandom_range(0, 3));
      x = pick_operand();
      y = pick_operand();
      if ($urandom_range(0, 5) == 0)
        run_op(o, x, y, 64'd0, $urandom_range(0, 32));
      else
        run_op(o, x, y, ref_result(o, x, y), -1);
    end

    wait_idle();
    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative 32-bit multiply/divide unit with HI/LO registers for the 5-stage MIPS pipeline, attached to the E stage. It accepts MULT/MULTU/DIV/DIVU operations, runs them over 33 cycles while the rest of the pipeline keeps flowing, and raises a stall request to the hazard control unit whenever a D-stage instruction touches HI/LO before the result is ready. It acts on the pipeline's stall/bubble decisions and also feeds new stall conditions back into them.

## Interface
- No parameters; the width is fixed at 32.
- clk  in  1  pipeline clock; all state updates on the rising edge
- clrn  in  1  asynchronous active-low reset
- start  in  1  E stage holds a valid mul/div instruction; qualified by ~e_bubble
- op  in  2  0=MULT, 1=MULTU, 2=DIV, 3=DIVU
- a  in  32  rs operand, also the dividend
- b  in  32  rt operand, also the divisor
- cancel  in  1  flush; aborts an in-flight operation
- e_bubble  in  1  E stage is a bubble this cycle; a start is ignored while it is high
- wr_hi, wr_lo  in  1  MTHI/MTLO commit from the E stage
- wdata  in  32  MTHI/MTLO data
- d_need_hilo  in  1  D-stage instruction is MFHI, MFLO, MTHI, MTLO, or a mul/div
- hi, lo  out  32  architectural HI/LO
- busy  out  1  an operation is in flight
- stall_hilo  out  1  busy && d_need_hilo; the hazard unit ORs this into its D stall

## Operation
- States: IDLE, RUN, FIX.
- IDLE: when start && ~e_bubble, latch the operand magnitudes (|a| and |b| for signed ops, raw values for unsigned), the result sign, the remainder sign and op. Clear the 64-bit accumulator and set count=0. Go to RUN.
- RUN, multiply: shift-add, one bit of the multiplier per cycle.
- RUN, divide: restoring division, one quotient bit per cycle into a 64-bit {rem,quot} register.
- RUN ends when count==31, then go to FIX.
- FIX, multiply: negate the 64-bit product if the result sign is negative, then {hi,lo}=product.
- FIX, divide: lo=quotient, negated if the operand signs differ; hi=remainder, negated if the dividend was negative.
- FIX then returns to IDLE.
- Divide by zero (b==0), both signed and unsigned: at FIX, hi=a (original value) and lo=32'hFFFF_FFFF.
- 0x8000_0000 / -1 (signed): lo=0x8000_0000 and hi=0. This falls out of the 32-bit magnitude path and needs no special case.
- wr_hi/wr_lo update HI/LO only in IDLE. In any other state they are ignored, which is legal because stall_hilo keeps them out of E.
- cancel in RUN or FIX: return to IDLE next cycle with HI/LO unchanged. cancel has priority over start and over FIX completion.
- A start while busy is ignored. The hazard unit prevents it through stall_hilo.

## Timing
- Reset values: state=IDLE, hi=0, lo=0, busy=0, stall_hilo=0, count=0.
- Start accepted at edge N. busy is high from after edge N through the cycle before edge N+33: 32 RUN cycles plus 1 FIX cycle.
- hi/lo take the result at edge N+33, and busy falls at the same edge.
- An MFHI held in D sees stall_hilo=1 through the last FIX cycle and reads the new value when it reaches E.
- busy is a registered, state-decoded signal. stall_hilo is combinational from busy and d_need_hilo.
- wr_hi and wr_lo in the same IDLE cycle both take wdata.
- A start in the same cycle as FIX completion cannot occur, because stall_hilo holds the mul/div in D.

## Structure
- muldiv_pkg holds:
  - the op encoding (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU);
  - the state enum (MD_IDLE, MD_RUN, MD_FIX);
  - the divide-by-zero LO constant 32'hFFFF_FFFF.
- No sub-module. The sign handling and the iterative datapath stay in one module of about 200 lines.

## Test plan
- MULT a=-3, b=7: busy high for exactly 33 cycles, then hi=32'hFFFF_FFFF and lo=32'hFFFF_FFEB.
- MULTU a=b=32'hFFFF_FFFF: hi=32'hFFFF_FFFE, lo=32'h0000_0001.
- DIV a=-7, b=2: lo=-3 (32'hFFFF_FFFD), hi=-1. DIVU a=7, b=0: hi=7, lo=32'hFFFF_FFFF.
- MFLO with d_need_hilo=1 during RUN: stall_hilo=1 every cycle until busy falls. Asserting wr_lo mid-RUN leaves lo unchanged.
- cancel at RUN cycle 10: busy=0 next cycle and hi/lo keep their prior values. A following MULTU 5×6 gives lo=30, hi=0.
- clrn asserted mid-RUN: outputs are 0 immediately (asynchronous); after release, start is accepted normally.
